// File: rtl/matrix_pkg.sv
// Shared geometry, FSM state type and row helper for the LED matrix frame buffer.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package matrix_pkg;

  localparam int MATRIX_ROWS = 8;
  localparam int MATRIX_COLS = 8;
  localparam int FRAME_W     = 64;
  localparam int PTR_W       = 3;

  typedef enum logic {
    FB_FILL,
    FB_PEND
  } fb_state_t;

  // Rotate one row left by a column; the top column wraps into column 0.
  function automatic logic [MATRIX_COLS-1:0] rot_row(input logic [MATRIX_COLS-1:0] row);
    return {row[MATRIX_COLS-2:0], row[MATRIX_COLS-1]};
  endfunction

endpackage

// File: rtl/matrix_fb_scroll.sv
// Frame-tick divider plus per-row left rotate of the front buffer (used only with MATRIX_FB_SCROLL_EN).
// Latency: step and frame_rot are combinational; the divider updates on the tick edge.
// Backpressure: none; follows i_FRAME_TICK and i_SCROLL directly.
import matrix_pkg::*;

module matrix_fb_scroll #(
  parameter int SCROLL_DIV = 4
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic               i_FRAME_TICK,
  input  logic               i_SCROLL,
  input  logic [FRAME_W-1:0] frame_in,
  output logic               step,
  output logic [FRAME_W-1:0] frame_rot
);

  localparam logic [7:0] DIV_LAST = 8'(SCROLL_DIV - 1);

  logic [7:0] div_q;

  assign step = i_SCROLL & i_FRAME_TICK & (div_q == DIV_LAST);

  // Count ticks while scrolling; restart after each step and whenever scrolling stops.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      div_q <= 8'd0;
    end else if (!i_SCROLL) begin
      div_q <= 8'd0;
    end else if (i_FRAME_TICK) begin
      div_q <= step ? 8'd0 : div_q + 8'd1;
    end
  end

  // Rotate every row independently so the image scrolls horizontally.
  always_comb begin
    frame_rot = '0;
    for (int r = 0; r < MATRIX_ROWS; r++) begin
      frame_rot[MATRIX_COLS*r +: MATRIX_COLS] = rot_row(frame_in[MATRIX_COLS*r +: MATRIX_COLS]);
    end
  end

endmodule

// File: rtl/matrix_frame_buffer.sv
// Double-buffered 8x8 LED frame store; row bytes fill a back buffer, commit swaps it at a frame tick.
// Latency: LAST accepted at edge N, swap on the next tick edge M>N, o_FRAME valid after M (>= 2 edges).
// Backpressure: o_WR_READY drops from commit until the swap tick; optional MATRIX_FB_SCROLL_EN adds scrolling.
import matrix_pkg::*;

module matrix_frame_buffer #(
  parameter logic [FRAME_W-1:0] RESET_FRAME = 64'h0,
  parameter int                 SCROLL_DIV  = 4
) (
  input  logic               i_CLK,
  input  logic               i_RST_N,
  input  logic               i_WR_VALID,
  output logic               o_WR_READY,
  input  logic [7:0]         i_WR_DATA,
  input  logic               i_WR_LAST,
  input  logic               i_FRAME_TICK,
  input  logic               i_SCROLL,
  output logic [FRAME_W-1:0] o_FRAME,
  output logic               o_SWAP_PEND,
  output logic [7:0]         o_FRAME_CNT
);

  fb_state_t          state_q;
  fb_state_t          state_d;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [FRAME_W-1:0] back_q;
  logic [FRAME_W-1:0] front_q;
  logic               wr_ready_q;
  logic               swap_pend_q;
  logic [7:0]         frame_cnt_q;

  logic               accept;
  logic               commit;
  logic               swap;
  logic               scroll_step;
  logic [FRAME_W-1:0] frame_rot;

  assign accept = i_WR_VALID & wr_ready_q;
  assign commit = accept & i_WR_LAST;
  // A tick only swaps once the commit has been registered, so a tick that
  // coincides with LAST acceptance is not enough.
  assign swap   = (state_q == FB_PEND) & i_FRAME_TICK;

`ifdef MATRIX_FB_SCROLL_EN
  matrix_fb_scroll #(
    .SCROLL_DIV (SCROLL_DIV)
  ) u_scroll (
    .i_CLK        (i_CLK),
    .i_RST_N      (i_RST_N),
    .i_FRAME_TICK (i_FRAME_TICK),
    .i_SCROLL     (i_SCROLL),
    .frame_in     (front_q),
    .step         (scroll_step),
    .frame_rot    (frame_rot)
  );
`else
  logic       unused_scroll;
  logic [7:0] unused_scroll_div;
  assign unused_scroll     = i_SCROLL;
  assign unused_scroll_div = 8'(SCROLL_DIV);
  assign scroll_step       = 1'b0;
  assign frame_rot         = front_q;
`endif

  // State register.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      state_q <= FB_FILL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: commit parks the frame, the following tick releases it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FB_FILL: if (commit) state_d = FB_PEND;
      FB_PEND: if (swap)   state_d = FB_FILL;
      default:             state_d = FB_FILL;
    endcase
  end

  // Write path: store accepted bytes at the row pointer; commit rewinds the pointer.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      back_q   <= RESET_FRAME;
      wr_ptr_q <= '0;
    end else if (accept) begin
      back_q[8*wr_ptr_q +: 8] <= i_WR_DATA;
      wr_ptr_q                <= i_WR_LAST ? '0 : wr_ptr_q + 1'b1;
    end
  end

  // Front buffer and swap counter: a swap always beats a scroll step on the same tick.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      front_q     <= RESET_FRAME;
      frame_cnt_q <= 8'd0;
    end else if (swap) begin
      front_q     <= back_q;
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end else if (scroll_step) begin
      front_q     <= frame_rot;
    end
  end

  // Registered handshake flags derived from the next state; ready stays low during reset.
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      wr_ready_q  <= 1'b0;
      swap_pend_q <= 1'b0;
    end else begin
      wr_ready_q  <= (state_d == FB_FILL);
      swap_pend_q <= (state_d == FB_PEND);
    end
  end

  assign o_FRAME     = front_q;
  assign o_WR_READY  = wr_ready_q;
  assign o_SWAP_PEND = swap_pend_q;
  assign o_FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_matrix_frame_buffer.sv
// Directed bench for matrix_frame_buffer: reset, full/short frames, tick/LAST collision, reset in PEND, scroll.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: the write task waits on o_WR_READY with a bounded cycle budget.
module tb_matrix_frame_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_data;
  logic        wr_last;
  logic        frame_tick;
  logic        scroll;
  logic [63:0] frame;
  logic        swap_pend;
  logic [7:0]  frame_cnt;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  matrix_frame_buffer #(
    .RESET_FRAME (64'hA5),
    .SCROLL_DIV  (2)
  ) dut (
    .i_CLK        (clk),
    .i_RST_N      (rst_n),
    .i_WR_VALID   (wr_valid),
    .o_WR_READY   (wr_ready),
    .i_WR_DATA    (wr_data),
    .i_WR_LAST    (wr_last),
    .i_FRAME_TICK (frame_tick),
    .i_SCROLL     (scroll),
    .o_FRAME      (frame),
    .o_SWAP_PEND  (swap_pend),
    .o_FRAME_CNT  (frame_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  // Present one byte (optionally with a coincident tick) and hold it until accepted.
  task automatic send(input logic [7:0] d, input logic last, input logic with_tick);
    int n;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_last  = last;
    n = 0;
    while (!wr_ready && n < 20) begin
      step();
      n++;
    end
    if (!wr_ready) begin
      total++;
      $error("FAIL send_timeout: observed ready=%b expected ready=1", wr_ready);
    end
    frame_tick = with_tick;
    step();
    wr_valid   = 1'b0;
    wr_last    = 1'b0;
    frame_tick = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    rst_n      = 1'b0;
    wr_valid   = 1'b0;
    wr_data    = 8'h00;
    wr_last    = 1'b0;
    frame_tick = 1'b0;
    scroll     = 1'b0;

    // Reset held for 3 cycles.
    step(); step(); step();
    chk("rst_frame", frame, 64'hA5);
    chk("rst_ready", {63'd0, wr_ready}, 64'd0);
    chk("rst_cnt",   {56'd0, frame_cnt}, 64'd0);
    chk("rst_pend",  {63'd0, swap_pend}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("ready_after_release", {63'd0, wr_ready}, 64'd1);

    // Full frame, walking one, tick 3 cycles after commit.
    b = 8'h01;
    for (int i = 0; i < 8; i++) begin
      send(b, (i == 7), 1'b0);
      b = {b[6:0], 1'b0};
    end
    chk("full_pend",  {63'd0, swap_pend}, 64'd1);
    chk("full_ready", {63'd0, wr_ready}, 64'd0);
    step(); step(); step();
    chk("full_pend_held",  {63'd0, swap_pend}, 64'd1);
    chk("full_front_held", frame, 64'hA5);
    tick();
    chk("full_frame", frame, 64'h8040201008040201);
    chk("full_cnt",   {56'd0, frame_cnt}, 64'd1);
    chk("full_pend_clr", {63'd0, swap_pend}, 64'd0);
    chk("full_ready_back", {63'd0, wr_ready}, 64'd1);

    // Clear back via 8 bytes without LAST (pointer wraps), then short frame.
    for (int i = 0; i < 8; i++) send(8'h00, 1'b0, 1'b0);
    chk("wrap_no_commit", {63'd0, swap_pend}, 64'd0);
    send(8'hFF, 1'b0, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    tick();
    chk("short_frame", frame, 64'h000000000000FFFF);
    chk("short_cnt",   {56'd0, frame_cnt}, 64'd2);

    // Tick coincident with LAST acceptance does not swap.
    send(8'h11, 1'b1, 1'b1);
    chk("coinc_no_swap", frame, 64'h000000000000FFFF);
    chk("coinc_cnt",     {56'd0, frame_cnt}, 64'd2);
    chk("coinc_pend",    {63'd0, swap_pend}, 64'd1);
    wr_valid = 1'b1;
    wr_data  = 8'h22;
    step(); step();
    chk("coinc_ready_low", {63'd0, wr_ready}, 64'd0);
    tick();
    wr_valid = 1'b0;
    chk("coinc_swap", frame, 64'h000000000000FF11);
    chk("coinc_cnt2", {56'd0, frame_cnt}, 64'd3);
    chk("coinc_ready_high", {63'd0, wr_ready}, 64'd1);

    // Reset during PEND after 5 bytes discards everything.
    for (int i = 0; i < 5; i++) send(8'(i + 1), (i == 4), 1'b0);
    chk("pend5_pend", {63'd0, swap_pend}, 64'd1);
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst2_frame", frame, 64'hA5);
    chk("rst2_cnt",   {56'd0, frame_cnt}, 64'd0);
    chk("rst2_pend",  {63'd0, swap_pend}, 64'd0);
    tick();
    chk("rst2_no_swap", frame, 64'hA5);
    chk("rst2_no_swap_cnt", {56'd0, frame_cnt}, 64'd0);
    send(8'h5A, 1'b1, 1'b0);
    tick();
    chk("rst2_ptr0", frame, 64'h5A);

    // Scroll: front = 0x01 in every row.
    for (int i = 0; i < 8; i++) send(8'h01, (i == 7), 1'b0);
    tick();
    chk("scroll_load", frame, 64'h0101010101010101);
    scroll = 1'b1;
    step();
`ifdef MATRIX_FB_SCROLL_EN
    tick(); step();
    tick(); step();
    chk("scroll_2ticks", frame, 64'h0202020202020202);
    tick(); step();
    tick(); step();
    chk("scroll_4ticks", frame, 64'h0404040404040404);
`else
    for (int i = 0; i < 10; i++) begin
      tick();
      step();
    end
    chk("scroll_disabled", frame, 64'h0101010101010101);
`endif
    chk("scroll_cnt", {56'd0, frame_cnt}, 64'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
